// File: rtl/disp_scheduler.sv
// Round-robin time-sharing of the 4-digit seven-segment display between three
// BCD sources, with a tick-based hold time and a blank gap between owners.
module disp_scheduler #(
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [2:0]  gnt,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic [1:0]  active_src,
    output logic        busy
);

    localparam int unsigned       HOLD_EFF  = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_EFF - 1);
    localparam logic [15:0]       BLANK_VAL = 16'hFFFF;
    localparam logic [1:0]        NO_SRC    = 2'b11;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       gnt_d;
    logic             done_d;
    logic [15:0]      bcd_d;
    logic [1:0]       src_d;
    logic             busy_d;
    logic [2:0]       pick;
    logic [15:0]      own_val;
    logic             own_req;

    // Any nibble above 9 becomes F so the digit multiplexer blanks it.
    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int d = 0; d < 4; d++) begin
            if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'hF;
        end
        return r;
    endfunction

    // First requester at or after ptr, wrapping 2->0; returns {found, index}.
    function automatic logic [2:0] pick_winner(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] res;
        int         s;
        res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            s = int'(p) + i;
            if (s >= 3) s = s - 3;
            if (r[s]) res = {1'b1, 2'(s)};
        end
        return res;
    endfunction

    always_comb begin
        pick    = pick_winner(req, ptr_q);
        own_req = |(req & gnt);
        case (active_src)
            2'd0:    own_val = val0;
            2'd1:    own_val = val1;
            default: own_val = val2;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt;
        done_d  = 1'b0;
        bcd_d   = bcd_out;
        src_d   = active_src;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    state_d = SHOW;
                    gnt_d   = 3'b001 << pick[1:0];
                    src_d   = pick[1:0];
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = (pick[1:0] == 2'd2) ? 2'd0 : pick[1:0] + 2'd1;
                end else begin
                    gnt_d  = 3'b000;
                    bcd_d  = BLANK_VAL;
                    src_d  = NO_SRC;
                    busy_d = 1'b0;
                end
            end
            SHOW: begin
                // Expiry takes priority over an early release in the same cycle.
                if (tick && cnt_q == HOLD_LAST) begin
                    state_d = BLANK;
                    gnt_d   = 3'b000;
                    done_d  = 1'b1;
                    bcd_d   = BLANK_VAL;
                    src_d   = NO_SRC;
                end else if (!own_req) begin
                    state_d = BLANK;
                    gnt_d   = 3'b000;
                    bcd_d   = BLANK_VAL;
                    src_d   = NO_SRC;
                end else begin
                    bcd_d = sanitize(own_val);
                    if (tick) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLANK: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= 2'd0;
            gnt        <= 3'b000;
            done       <= 1'b0;
            bcd_out    <= BLANK_VAL;
            active_src <= NO_SRC;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt        <= gnt_d;
            done       <= done_d;
            bcd_out    <= bcd_d;
            active_src <= src_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler: two builds (HOLD_TICKS=4 and 0) share the
// stimulus; a per-cycle reference model queues expected outputs for a monitor.
module tb_disp_scheduler;

    typedef struct packed {
        logic [2:0]  gnt;
        logic        done;
        logic [15:0] bcd;
        logic [1:0]  src;
        logic        busy;
    } exp_t;

    localparam exp_t RST_EXP = '{gnt: 3'b000, done: 1'b0, bcd: 16'hFFFF, src: 2'b11, busy: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [2:0]  req;
    logic [15:0] val0, val1, val2;
    logic [2:0]  d_gnt  [2];
    logic        d_done [2];
    logic [15:0] d_bcd  [2];
    logic [1:0]  d_src  [2];
    logic        d_busy [2];

    int total = 0;
    int bad   = 0;
    int tick_per = 10;
    bit rec_en = 1'b0;
    int order[$];

    always #5 clk = ~clk;

    disp_scheduler #(.HOLD_TICKS(4), .CNT_W(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .gnt(d_gnt[0]), .done(d_done[0]), .bcd_out(d_bcd[0]),
        .active_src(d_src[0]), .busy(d_busy[0])
    );

    disp_scheduler #(.HOLD_TICKS(0), .CNT_W(4)) u_h0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .gnt(d_gnt[1]), .done(d_done[1]), .bcd_out(d_bcd[1]),
        .active_src(d_src[1]), .busy(d_busy[1])
    );

    // Reference model: phase 0 idle, 1 showing, 2 blank gap.
    int   m_phase [2];
    int   m_owner [2];
    int   m_left  [2];
    int   m_next  [2];
    exp_t m_out   [2];
    exp_t q0[$];
    exp_t q1[$];

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [15:0] val_of(input int s);
        return (s == 0) ? val0 : (s == 1) ? val1 : val2;
    endfunction

    function automatic logic [15:0] digits_clean(input logic [15:0] v);
        int unsigned r, nib;
        r = 0;
        for (int d = 0; d < 4; d++) begin
            nib = (int'(v) >> (4 * d)) & 15;
            if (nib > 9) nib = 15;
            r = r | (nib << (4 * d));
        end
        return 16'(r);
    endfunction

    task automatic model_reset(input int k);
        m_phase[k] = 0;
        m_owner[k] = -1;
        m_left[k]  = 0;
        m_next[k]  = 0;
        m_out[k]   = RST_EXP;
    endtask

    task automatic model_step(input int k);
        exp_t o;
        int   w;
        o = m_out[k];
        o.done = 1'b0;
        if (m_phase[k] == 0) begin
            w = -1;
            for (int i = 0; i < 3; i++) begin
                int s = (m_next[k] + i) % 3;
                if (w < 0 && req[s]) w = s;
            end
            if (w >= 0) begin
                m_phase[k] = 1;
                m_owner[k] = w;
                m_left[k]  = hold_of(k);
                m_next[k]  = (w + 1) % 3;
                o.gnt  = 3'(1 << w);
                o.src  = 2'(w);
                o.busy = 1'b1;
            end else begin
                o = RST_EXP;
            end
        end else if (m_phase[k] == 1) begin
            if ((tick && m_left[k] == 1) || !req[m_owner[k]]) begin
                o.done     = tick && m_left[k] == 1;
                m_phase[k] = 2;
                o.gnt = 3'b000;
                o.bcd = 16'hFFFF;
                o.src = 2'b11;
            end else begin
                if (tick) m_left[k] = m_left[k] - 1;
                o.bcd = digits_clean(val_of(m_owner[k]));
            end
        end else if (tick) begin
            m_phase[k] = 0;
            o.busy = 1'b0;
        end
        m_out[k] = o;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
            q0.delete();
            q1.delete();
        end else begin
            model_step(0);
            model_step(1);
            q0.push_back(m_out[0]);
            q1.push_back(m_out[1]);
        end
    end

    task automatic check_rec(input string name, input int k, input exp_t want);
        exp_t got;
        got.gnt  = d_gnt[k];
        got.done = d_done[k];
        got.bcd  = d_bcd[k];
        got.src  = d_src[k];
        got.busy = d_busy[k];
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got gnt=%b done=%b bcd=%h src=%0d busy=%b want gnt=%b done=%b bcd=%h src=%0d busy=%b",
                     name, k, $time, got.gnt, got.done, got.bcd, got.src, got.busy,
                     want.gnt, want.done, want.bcd, want.src, want.busy);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // Monitor: every cycle out of reset each DUT presents a fresh output word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_rec("sb", 0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_rec("sb", 1, e);
            end
        end
    end

    logic [2:0] prev_g = 3'b000;
    always @(negedge clk) begin
        if (rec_en && prev_g == 3'b000 && d_gnt[0] != 3'b000)
            order.push_back(d_gnt[0] == 3'b001 ? 0 : d_gnt[0] == 3'b010 ? 1 : 2);
        prev_g = d_gnt[0];
    end

    initial begin
        int tk_cnt;
        tk_cnt = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tk_cnt == 0) begin
                tick = 1'b1;
                tk_cnt = (tick_per != 0) ? tick_per - 1 : int'($urandom_range(7, 3));
            end else begin
                tick = 1'b0;
                tk_cnt--;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (d_busy[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_val({name, "_idle_timeout"}, n, 0);
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        while (d_gnt[0] == 3'b000 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_val({name, "_gnt_timeout"}, n, 0);
    endtask

    task automatic reset_checks(input string name);
        check_rec(name, 0, RST_EXP);
        check_rec(name, 1, RST_EXP);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        val0  = 16'h0000;
        val1  = 16'h0000;
        val2  = 16'h0000;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;

        // Single source with a fixed 10-cycle tick.
        req  = 3'b001;
        val0 = 16'h1234;
        repeat (100) @(negedge clk);
        req = 3'b000;
        repeat (30) @(negedge clk);

        // Round-robin from a fresh pointer.
        rst_n = 1'b0;
        #1 reset_checks("rr_reset");
        @(negedge clk);
        rst_n = 1'b1;
        val0 = 16'h0001;
        val1 = 16'h0002;
        val2 = 16'h0003;
        order.delete();
        rec_en = 1'b1;
        req = 3'b111;
        for (int n = 0; n < 600 && order.size() < 4; n++) @(negedge clk);
        rec_en = 1'b0;
        check_val("rr_count", order.size() >= 4 ? 4 : order.size(), 4);
        if (order.size() >= 4) begin
            check_val("rr_order0", order[0], 0);
            check_val("rr_order1", order[1], 1);
            check_val("rr_order2", order[2], 2);
            check_val("rr_order3", order[3], 0);
        end

        // Sanitize and live update on source 0.
        req = 3'b000;
        wait_idle("san");
        val0 = 16'h9A05;
        req  = 3'b001;
        wait_gnt("san");
        repeat (5) @(negedge clk);
        val0 = 16'h0042;
        repeat (10) @(negedge clk);

        // Early release of source 1, then source 2 must come next.
        req = 3'b000;
        wait_idle("er");
        req = 3'b010;
        wait_gnt("er");
        check_val("er_gnt1", int'(d_gnt[0]), 2);
        repeat (12) @(negedge clk);
        req = 3'b101;
        wait_idle("er2");
        wait_gnt("er2");
        check_val("er_next_src2", int'(d_gnt[0]), 4);

        // Randomized requests, values and tick spacing.
        tick_per = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(7, 0) == 0) req[$urandom_range(2, 0)] ^= 1'b1;
            if ($urandom_range(15, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0:       val0 = 16'($urandom());
                    1:       val1 = 16'($urandom());
                    default: val2 = 16'($urandom());
                endcase
            end
        end

        // Asynchronous reset in the middle of SHOW.
        req = 3'b111;
        wait_gnt("ar");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt("ar2");
        check_val("ar_src0_wins", int'(d_gnt[0]), 1);
        repeat (40) @(negedge clk);

        req = 3'b000;
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scheduler.md
Name: disp_scheduler

Overview:
- Time-shares the 4-digit seven-segment display between three requesters, each offering a 16-bit packed BCD value.
- Sits upstream of the digit multiplexer: its bcd_out drives the multiplexer's bcd_in.
- Its tick input comes from the clock divider output, edge-converted to a 1-cycle enable pulse.
- Round-robin arbitration with req/gnt handshake, a hold time measured in ticks, and a blank gap between owners.

Parameters:
- HOLD_TICKS, 4, number of tick pulses a granted source owns the display; 0 is treated as 1.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_TICKS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- tick  in  1  1-cycle enable pulse, the display time base.
- req  in  3  per-source display request, level; bit i belongs to source i.
- val0  in  16  source 0 BCD value, nibble [15:12] is the leftmost digit.
- val1  in  16  source 1 BCD value.
- val2  in  16  source 2 BCD value.
- gnt  out  3  one-hot grant, registered.
- done  out  1  1-cycle pulse when a grant ends on hold expiry.
- bcd_out  out  16  value to the digit multiplexer.
- active_src  out  2  index of the granted source; 2'b11 when none is granted.
- busy  out  1  high in SHOW and BLANK.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=0, done=0, bcd_out=16'hFFFF (all digits blank), active_src=2'b11, busy=0.
  - Round-robin pointer set so priority order is 0,1,2.
  - Hold counter cleared.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - On any req bit high, pick the first requester at or after ptr, wrapping 2->0.
  - Next cycle: state=SHOW, gnt=onehot(winner), active_src=winner, busy=1, counter=0, ptr=winner+1 mod 3.
  - Latency req->gnt is exactly 1 cycle.
  - With req=0, stay in IDLE with outputs at reset values.
- SHOW:
  - Each cycle bcd_out <= sanitize(val of granted source), so live value updates appear 1 cycle later.
  - sanitize: any nibble > 9 is output as 4'hF, blanking that digit.
  - The counter increments on each tick. A tick in the same cycle that gnt first goes high is not counted.
  - Hold expiry: when a tick arrives with counter == max(HOLD_TICKS,1)-1:
    - next cycle gnt=0, done=1 for one cycle, state=BLANK, bcd_out=16'hFFFF, active_src=2'b11.
  - Early release: if the granted source's req is low in any SHOW cycle:
    - next cycle gnt=0, state=BLANK, bcd_out=16'hFFFF, done stays 0.
  - If early release and hold expiry occur in the same cycle, expiry wins and done=1.
- BLANK:
  - Display held blank and all requests ignored.
  - On the next tick pulse, state=IDLE next cycle and busy=0.
  - Minimum gap is one full tick period. A tick in the cycle BLANK is entered does not count; BLANK waits for a later tick.
- Round-robin rules:
  - Non-granted requests stay pending, since req is a level.
  - A source that holds req high continuously is re-granted only after the other pending sources have each been served once.
- Output rules:
  - gnt is never multi-hot.
  - gnt, done and bcd_out are registered outputs, with no combinational path from req or val.
- Reset mid-operation drops gnt immediately, asynchronously.

Test Plan:
- Single source:
  - Stimulus: rst_n released; req=3'b001; val0=16'h1234; tick every 10 cycles.
  - Response: gnt=001 one cycle after req; bcd_out=16'h1234 one cycle after that; done pulses after the 4th counted tick; bcd_out=FFFF through BLANK; IDLE one cycle after the next tick.
- Round-robin:
  - Stimulus: req=3'b111 held; val0/1/2=0001/0002/0003.
  - Response: grant order 0,1,2,0; active_src follows 0,1,2,0; each grant is separated by a BLANK gap of at least one tick.
- Early release:
  - Stimulus: source 1 granted; req[1] dropped after 1 tick.
  - Response: gnt=000 one cycle later; done stays 0; bcd_out=FFFF; pointer advances so source 2 is next.
- Sanitize and live update:
  - Stimulus: source 0 granted with val0=16'h9A05, then changed to 16'h0042 mid-hold.
  - Response: bcd_out=16'h9F05, then 16'h0042 one cycle after the change.
- Async reset mid-SHOW:
  - Stimulus: rst_n pulsed low between clock edges.
  - Response: gnt=0, bcd_out=FFFF, active_src=11 immediately, without waiting for a clock edge; after release, source 0 wins if all sources request.
- HOLD_TICKS=0 boundary:
  - Stimulus: build with HOLD_TICKS=0.
  - Response: behaves exactly as HOLD_TICKS=1, with done after the first counted tick.
